// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller: forward-mux
// select encodings and the bit layout of the per-stage register-tag bundles.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Tag layout, LSB first: memread, regwrite, rd, rs2, rs1. EX/MEM keeps the
  // low [aw+1:0] slice of an ID/EX tag and MEM/WB keeps the [aw+1:1] slice.
  localparam int unsigned TAG_MEMREAD  = 0;
  localparam int unsigned TAG_REGWRITE = 1;
  localparam int unsigned TAG_RD_LSB   = 2;

  function automatic int unsigned tag_rs2_lsb(input int unsigned aw);
    return TAG_RD_LSB + aw;
  endfunction

  function automatic int unsigned tag_rs1_lsb(input int unsigned aw);
    return TAG_RD_LSB + 2 * aw;
  endfunction

  function automatic int unsigned idex_w(input int unsigned aw);
    return TAG_RD_LSB + 3 * aw;
  endfunction

  function automatic int unsigned exmem_w(input int unsigned aw);
    return TAG_RD_LSB + aw;
  endfunction

  function automatic int unsigned memwb_w(input int unsigned aw);
    return TAG_REGWRITE + aw;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode/EX-side signals between the pipeline (master) and the hazard unit
// (slave). Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              valid_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              regwrite_d;
  logic              memread_d;
  logic              branch_taken_e;
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  if (REG_AW < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_forward_unit_if: REG_AW and CNT_W must be at least 1");
  end

  modport master (
    output valid_d, rs1_d, rs2_d, rd_d, regwrite_d, memread_d, branch_taken_e,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e
`ifdef HAZARD_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  valid_d, rs1_d, rs2_d, rd_d, regwrite_d, memread_d, branch_taken_e,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e
`ifdef HAZARD_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_tag_reg.sv
// One stage-boundary register for the hazard tag pipeline; a bubble loads
// all-zero tags so the slot can never act as a forward or stall source.
module hazard_tag_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble_i,
  input  logic [W-1:0] tag_d_i,
  output logic [W-1:0] tag_q_o
);

  logic [W-1:0] tag_q;

  // NOTE: sequential state uses non-blocking assignment so every stage samples
  // its predecessor's pre-edge value and the pipeline advances in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= bubble_i ? '0 : tag_d_i;
    end
  end

  assign tag_q_o = tag_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage RV32I core: EX forward selects, load-use
// stall and branch flush. Optional saturating counters under HAZARD_PERF_EN.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave hz
);

  localparam int unsigned IDEX_W  = idex_w(REG_AW);
  localparam int unsigned EXMEM_W = exmem_w(REG_AW);
  localparam int unsigned MEMWB_W = memwb_w(REG_AW);
  localparam int unsigned RS2_LSB = tag_rs2_lsb(REG_AW);
  localparam int unsigned RS1_LSB = tag_rs1_lsb(REG_AW);

  if (REG_AW < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_forward_unit: REG_AW and CNT_W must be at least 1");
  end

  logic [IDEX_W-1:0]  id_ex_d;
  logic [IDEX_W-1:0]  id_ex_q;
  logic [EXMEM_W-1:0] ex_mem_q;
  logic [MEMWB_W-1:0] mem_wb_q;
  logic               id_ex_bubble;

  logic [REG_AW-1:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic               ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic               mem_fwd_ok, wb_fwd_ok;
  logic               load_use, flush, stall;
  fwd_sel_e           fwd_a, fwd_b;

  assign id_ex_d = {hz.rs1_d, hz.rs2_d, hz.rd_d, hz.regwrite_d, hz.memread_d};
  assign id_ex_bubble = stall || flush || !hz.valid_d;

  hazard_tag_reg #(.W(IDEX_W)) u_id_ex (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble_i(id_ex_bubble),
    .tag_d_i (id_ex_d),
    .tag_q_o (id_ex_q)
  );

  hazard_tag_reg #(.W(EXMEM_W)) u_ex_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble_i(1'b0),
    .tag_d_i (id_ex_q[EXMEM_W-1:0]),
    .tag_q_o (ex_mem_q)
  );

  hazard_tag_reg #(.W(MEMWB_W)) u_mem_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble_i(1'b0),
    .tag_d_i (ex_mem_q[EXMEM_W-1:TAG_REGWRITE]),
    .tag_q_o (mem_wb_q)
  );

  assign ex_rs1       = id_ex_q[RS1_LSB +: REG_AW];
  assign ex_rs2       = id_ex_q[RS2_LSB +: REG_AW];
  assign ex_rd        = id_ex_q[TAG_RD_LSB +: REG_AW];
  assign ex_memread   = id_ex_q[TAG_MEMREAD];
  assign mem_rd       = ex_mem_q[TAG_RD_LSB +: REG_AW];
  assign mem_regwrite = ex_mem_q[TAG_REGWRITE];
  assign mem_memread  = ex_mem_q[TAG_MEMREAD];
  assign wb_rd        = mem_wb_q[TAG_RD_LSB-1 +: REG_AW];
  assign wb_regwrite  = mem_wb_q[TAG_REGWRITE-1];

  // A load in MEM has no data yet, so it is never a MEM-stage source.
  assign mem_fwd_ok = mem_regwrite && !mem_memread && (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a select unassigned and no latch is inferred.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (mem_fwd_ok && (mem_rd == ex_rs1))     fwd_a = FWD_MEM;
    else if (wb_fwd_ok && (wb_rd == ex_rs1))  fwd_a = FWD_WB;
    if (mem_fwd_ok && (mem_rd == ex_rs2))     fwd_b = FWD_MEM;
    else if (wb_fwd_ok && (wb_rd == ex_rs2))  fwd_b = FWD_WB;
  end

  assign load_use = ex_memread && (ex_rd != '0) && hz.valid_d &&
                    ((ex_rd == hz.rs1_d) || (ex_rd == hz.rs2_d));
  assign flush    = hz.branch_taken_e;
  // A taken branch squashes the dependent instruction, so it must not stall.
  assign stall    = load_use && !flush;

  assign hz.fwd_a_e = fwd_a;
  assign hz.fwd_b_e = fwd_b;
  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_d = flush;
  assign hz.flush_e = flush;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit; counter checks are compiled
// in when HAZARD_PERF_EN is defined.
module tb_hazard_forward_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(32)) hz_if ();

  hazard_forward_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    hz_if.valid_d    = v;
    hz_if.rs1_d      = r1;
    hz_if.rs2_d      = r2;
    hz_if.rd_d       = rd;
    hz_if.regwrite_d = rw;
    hz_if.memread_d  = mr;
    #1;
  endtask

  task automatic nop();
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    hz_if.branch_taken_e = 1'b0;
    nop();
    repeat (2) tick();

    // Reset state
    check("rst_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    check("rst_fwd_b", 32'(hz_if.fwd_b_e), 32'd0);
    check("rst_stall_f", 32'(hz_if.stall_f), 32'd0);
    check("rst_stall_d", 32'(hz_if.stall_d), 32'd0);
    check("rst_flush_d", 32'(hz_if.flush_d), 32'd0);
    check("rst_flush_e", 32'(hz_if.flush_e), 32'd0);
`ifdef HAZARD_PERF_EN
    check("rst_stall_cnt", hz_if.stall_cnt, 32'd0);
    check("rst_flush_cnt", hz_if.flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MEM forward: add x5 ; sub x6,x5,x1
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    check("mem_no_stall", 32'(hz_if.stall_d), 32'd0);
    tick();
    nop();
    check("mem_fwd_a", 32'(hz_if.fwd_a_e), 32'd2);
    check("mem_fwd_b", 32'(hz_if.fwd_b_e), 32'd0);
    drain();

    // WB forward: add x5 ; nop ; or x7,x1,x5
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_d(1'b1, 5'd1, 5'd5, 5'd7, 1'b1, 1'b0);
    tick();
    nop();
    check("wb_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    check("wb_fwd_b", 32'(hz_if.fwd_b_e), 32'd1);
    drain();

    // Double hit: add x5 ; add x5 ; and x8,x5,x5 -> newest (MEM) wins
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0);
    tick();
    nop();
    check("dbl_fwd_a", 32'(hz_if.fwd_a_e), 32'd2);
    check("dbl_fwd_b", 32'(hz_if.fwd_b_e), 32'd2);
    drain();

    // Load-use: lw x9 ; add x10,x9,x2
    set_d(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
    check("lu_stall_f", 32'(hz_if.stall_f), 32'd1);
    check("lu_stall_d", 32'(hz_if.stall_d), 32'd1);
    check("lu_no_flush", 32'(hz_if.flush_e), 32'd0);
    tick();
    check("lu_one_cycle", 32'(hz_if.stall_d), 32'd0);
    check("lu_bubble_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    tick();
    nop();
    check("lu_fwd_a_wb", 32'(hz_if.fwd_a_e), 32'd1);
    check("lu_fwd_b", 32'(hz_if.fwd_b_e), 32'd0);
`ifdef HAZARD_PERF_EN
    check("lu_stall_cnt", hz_if.stall_cnt, 32'd1);
`endif
    drain();

    // x0 is never a source: MEM, WB and load-use paths
    set_d(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    check("x0_no_stall", 32'(hz_if.stall_d), 32'd0);
    tick();
    nop();
    check("x0_mem_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    check("x0_mem_fwd_b", 32'(hz_if.fwd_b_e), 32'd0);
    drain();
    set_d(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_d(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    tick();
    nop();
    check("x0_wb_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    drain();
    set_d(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    check("x0_load_no_stall", 32'(hz_if.stall_d), 32'd0);
    drain();

    // Branch during load-use candidate: flush wins, next ID/EX is a bubble
    set_d(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    hz_if.branch_taken_e = 1'b1;
    set_d(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
    check("br_flush_d", 32'(hz_if.flush_d), 32'd1);
    check("br_flush_e", 32'(hz_if.flush_e), 32'd1);
    check("br_stall_f", 32'(hz_if.stall_f), 32'd0);
    check("br_stall_d", 32'(hz_if.stall_d), 32'd0);
    tick();
    hz_if.branch_taken_e = 1'b0;
    set_d(1'b1, 5'd10, 5'd9, 5'd11, 1'b1, 1'b0);
    check("br_flush_one_cycle", 32'(hz_if.flush_e), 32'd0);
    check("br_after_no_stall", 32'(hz_if.stall_d), 32'd0);
    tick();
    nop();
    check("br_bubble_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    check("br_load_fwd_b", 32'(hz_if.fwd_b_e), 32'd1);
`ifdef HAZARD_PERF_EN
    check("br_flush_cnt", hz_if.flush_cnt, 32'd1);
    check("br_stall_cnt", hz_if.stall_cnt, 32'd1);
`endif
    drain();

    // Asynchronous reset in the middle of a stall with a live forward
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
    check("pre_rst_stall", 32'(hz_if.stall_d), 32'd1);
    check("pre_rst_fwd_a", 32'(hz_if.fwd_a_e), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall_f", 32'(hz_if.stall_f), 32'd0);
    check("mid_rst_stall_d", 32'(hz_if.stall_d), 32'd0);
    check("mid_rst_fwd_a", 32'(hz_if.fwd_a_e), 32'd0);
    check("mid_rst_fwd_b", 32'(hz_if.fwd_b_e), 32'd0);
    check("mid_rst_flush", 32'(hz_if.flush_e), 32'd0);
`ifdef HAZARD_PERF_EN
    check("mid_rst_stall_cnt", hz_if.stall_cnt, 32'd0);
    check("mid_rst_flush_cnt", hz_if.flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_empty", 32'(hz_if.stall_d), 32'd0);
    tick();
    check("post_rst_no_fwd", 32'(hz_if.fwd_a_e), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 5-stage RV32I core. It tracks the register tags of instructions in flight through EX, MEM and WB, and drives the 2-bit select inputs of the operand-A/B forwarding muxes in EX. It also raises load-use stalls and branch flushes. It is the control end of the forwarding datapath: the muxes consume what this block decides.

## Interface
Parameters:
- `REG_AW`, default 5: register-index width.
- `CNT_W`, default 32: perf-counter width (used only with `HAZARD_PERF_EN`).

Ports:
- `clk`  in  1: core clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_d`  in  1: decode-stage instruction is valid.
- `rs1_d`, `rs2_d`, `rd_d`  in  REG_AW: decode-stage register indices.
- `regwrite_d`  in  1: decode instruction writes rd.
- `memread_d`  in  1: decode instruction is a load.
- `branch_taken_e`  in  1: EX resolved a taken branch or jump.
- `fwd_a_e`, `fwd_b_e`  out  2: forwarding selects for EX operands A and B.
- `stall_f`, `stall_d`  out  1: hold PC and IF/ID.
- `flush_d`, `flush_e`  out  1: squash IF/ID and ID/EX.
- `stall_cnt`, `flush_cnt`  out  CNT_W: only with `HAZARD_PERF_EN`.

## Operation
- Internal tag pipeline, registered on `clk`:
  - ID/EX holds {rs1, rs2, rd, regwrite, memread}.
  - EX/MEM holds {rd, regwrite, memread}.
  - MEM/WB holds {rd, regwrite}.
- Advance each cycle: ID/EX ← decode inputs; EX/MEM ← ID/EX; MEM/WB ← EX/MEM.
- Bubble: the ID/EX load is replaced by all-zero tags when `stall_d`, `flush_e` or `!valid_d` is asserted. EX/MEM and MEM/WB always advance.
- Forward select, per operand, with rsX taken from ID/EX:
  - Select FWD_MEM (2'b10) if EX/MEM.regwrite && !EX/MEM.memread && EX/MEM.rd != 0 && EX/MEM.rd == rsX.
  - Otherwise select FWD_WB (2'b01) if MEM/WB.regwrite && MEM/WB.rd != 0 && MEM/WB.rd == rsX.
  - Otherwise select FWD_REG (2'b00).
  - Encoding 2'b11 is never driven.
- Load-use: `stall_f` = `stall_d` = ID/EX.memread && ID/EX.rd != 0 && valid_d && (ID/EX.rd == rs1_d || ID/EX.rd == rs2_d).
  - The load reaches WB when the dependent instruction is in EX, so the dependent instruction sees FWD_WB.
- Branch: `flush_d` = `flush_e` = `branch_taken_e`.
- Simultaneous branch and load-use: the flush wins, and `stall_f`/`stall_d` are forced to 0.
- x0 is never a forward or stall source.

## Timing
- `fwd_*`, `stall_*` and `flush_*` are combinational from the tag registers and current inputs, with zero-cycle latency. Downstream pipeline registers sample them at the same edge.
- Load-use stall lasts exactly 1 cycle per hazard; the bubble clears the condition on the next cycle.
- Flush lasts 1 cycle. The cycle after it, ID/EX contains a bubble.
- Reset (`rst_n` = 0, asynchronous):
  - All tag registers clear.
  - `fwd_a_e` = `fwd_b_e` = 2'b00.
  - `stall_*` = 0 and `flush_*` = 0, provided `branch_taken_e` is 0.
  - Counters are 0.
- Reset mid-stall abandons the stall; the first post-reset cycle sees an empty pipeline.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on each cycle `stall_d` = 1.
  - `flush_cnt` increments on each cycle `flush_e` = 1.
  - Both saturate at all-ones and clear on reset.
- `HAZARD_PERF_EN` undefined: the counter ports and registers are absent, with no other behavioural change.

## Structure
- Shared package/header `hazard_pkg` contains:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - The stage-tag bundle layout.
- One sub-module, `hazard_tag_reg`: a resettable tag register with a bubble-insert input, instantiated once per stage boundary.
- Compare/select logic stays in the top.

## Test plan
- **MEM forward:** `add x5` followed by `sub x6,x5,x1` → in the cycle `sub` is in EX, `fwd_a_e` = 2'b10 and `fwd_b_e` = 2'b00.
- **WB forward:** `add x5`, `nop`, `or x7,x1,x5` → `fwd_b_e` = 2'b01.
- **Double hit:** `add x5`, `add x5`, `and x8,x5,x5` → both selects = 2'b10, so the newest value wins.
- **Load-use:** `lw x9` then `add x10,x9,x2` → `stall_f` = `stall_d` = 1 for one cycle and a bubble enters EX. Next, `fwd_a_e` = 2'b01. With `HAZARD_PERF_EN`, `stall_cnt` = 1.
- **x0:** `add x0,...` then `add x1,x0,x0` → selects stay 2'b00 and there is no stall.
- **Branch during load-use candidate:** assert `branch_taken_e` in the stall cycle → flush = 1 and stall = 0. The next ID/EX is a bubble. Deassert `rst_n` mid-sequence → all outputs are 0 immediately.
